seq_shifter: RTL and testbench

Multi-cycle iterative shifter: one-bit shift per clock, start/busy/done handshake.
- Operation set matches the combinational barrelshifter: `in`, `shamt`, `dir`, `out`.
- Sits where area matters more than latency; replaces the log-depth mux tree with one shift register plus a down-counter.
- Used by the multi-cycle datapath controller, which issues `start` and waits for `done`.

---
 rtl/seq_shifter.sv | 109 ++++++++++
 tb/tb_seq_shifter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - one-bit-per-clock iterative shifter with start/busy/done; SEQ_SHIFTER_ARITH_EN selects arithmetic right shift
module seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   wreg_q, wreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               fill;
  logic [WIDTH-1:0]   shifted;

`ifdef SEQ_SHIFTER_ARITH_EN
  // Arithmetic right shift replicates the sign bit on every step.
  assign fill = wreg_q[WIDTH-1];
`else
  // Logical right shift fills with zero.
  assign fill = 1'b0;
`endif

  // One-bit step of the work register in the latched direction.
  always_comb begin
    shifted = wreg_q;
    if (dir_q) begin
      shifted = {wreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {fill, wreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: accept in IDLE, step in SHIFT, publish on DONE entry.
  always_comb begin
    state_d = state_q;
    wreg_d  = wreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wreg_d = in;
          cnt_d  = shamt;
          dir_d  = dir;
          if (shamt != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
            out_d   = in;
          end
        end
      end
      ST_SHIFT: begin
        wreg_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        // Exit on cnt==1 so the counter never wraps through zero.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
          out_d   = shifted;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wreg_q  <= wreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed and random checks of seq_shifter against an arithmetic reference
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in = 8'h00;
  logic [2:0] shamt = 3'd0;
  logic       dir = 1'b0;
  logic [7:0] out;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] prev_out = 8'h00;

  seq_shifter #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .shamt (shamt),
    .dir   (dir),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int s, input logic d);
    logic signed [7:0] sa;
    sa = a;
    if (d) return a << s;
`ifdef SEQ_SHIFTER_ARITH_EN
    return sa >>> s;
`else
    return a >> s;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation; poke re-asserts start mid-SHIFT to prove it is ignored.
  task automatic run_op(input logic [7:0] a, input logic [2:0] s, input logic d, input bit poke);
    logic [7:0] exp;
    exp = ref_shift(a, int'(s), d);
    @(negedge clk);
    start = 1'b1; in = a; shamt = s; dir = d;
    @(posedge clk); #1;
    start = 1'b0; in = 8'($urandom); shamt = 3'($urandom); dir = 1'($urandom);
    if (s == 3'd0) begin
      check("done_imm", {7'd0, done}, 8'd1);
      check("out_imm", out, exp);
      check("busy_imm", {7'd0, busy}, 8'd1);
    end else begin
      check("busy_acc", {7'd0, busy}, 8'd1);
      check("done_acc", {7'd0, done}, 8'd0);
      check("out_hold", out, prev_out);
      for (int i = 1; i <= int'(s); i++) begin
        if (poke && i == 1) begin
          start = 1'b1; in = 8'h01; shamt = 3'd1; dir = 1'b1;
        end
        @(posedge clk); #1;
        if (i == int'(s)) begin
          start = 1'b0;
          check("done_pulse", {7'd0, done}, 8'd1);
          check("out_res", out, exp);
        end else begin
          check("busy_shift", {7'd0, busy}, 8'd1);
          check("done_early", {7'd0, done}, 8'd0);
          check("out_hold", out, prev_out);
        end
      end
    end
    @(posedge clk); #1;
    check("done_low", {7'd0, done}, 8'd0);
    check("busy_low", {7'd0, busy}, 8'd0);
    check("out_keep", out, exp);
    prev_out = exp;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'b00000001, 3'd7, 1'b1, 1'b0);
    check("t1_lit", out, 8'b10000000);
    run_op(8'b00001101, 3'd2, 1'b0, 1'b0);
    check("t2_lit", out, 8'b00000011);
    run_op(8'hA5, 3'd0, 1'b1, 1'b0);
    check("t3_lit", out, 8'hA5);
    run_op(8'hFF, 3'd5, 1'b1, 1'b1);
    check("t4_lit", out, 8'hE0);

    // Reset in the middle of a shamt=6 operation.
    @(negedge clk);
    start = 1'b1; in = 8'h3C; shamt = 3'd6; dir = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t5_out", out, 8'h00);
    check("t5_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_nodone", {7'd0, done}, 8'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_out = 8'h00;
    run_op(8'h0F, 3'd1, 1'b1, 1'b0);
    check("t5_lit", out, 8'h1E);

    run_op(8'h90, 3'd2, 1'b0, 1'b0);
`ifdef SEQ_SHIFTER_ARITH_EN
    check("t6_lit", out, 8'hE4);
`else
    check("t6_lit", out, 8'h24);
`endif

    for (int n = 0; n < 40; n++) begin
      run_op(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
